bounce_gen: RTL and testbench
=============================

BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 SHALL have parameter BOUNCES, default 3: glitch pairs per transition, range 0..15.
REQ-002 SHALL have parameter GAP_W, default 10: gap field width, range 1..16.
REQ-003 SHALL have parameter SETTLE, default 4096: stable-hold cycles after the last toggle, range 1..2^20.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: pb electrical level is the pressed state XOR ACTIVE_LOW.
REQ-005 SHALL have port clk  input  1  sole clock.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  1  transition request.
REQ-008 SHALL have port req_press  input  1  requested state: 1 = press, 0 = release.
REQ-009 SHALL have port req_ready  output  1  request can be accepted.
REQ-010 SHALL have port seed_load  input  1  load seed into the LFSR.
REQ-011 SHALL have port seed  input  16  LFSR seed value.
REQ-012 SHALL have port pb  output  1  emulated bouncing pushbutton line.
REQ-013 SHALL have port busy  output  1  transition in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement the states IDLE, BOUNCE, SETTLE and FIN; all outputs SHALL be registered.
REQ-016 SHALL drive req_ready high only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both high.
REQ-017 SHALL latch req_press as the target on acceptance; req_valid SHALL be ignored outside IDLE.
REQ-018 SHALL, on a request whose target equals the current logical state, enter FIN with no pb toggles; done SHALL be high in the cycle after acceptance.
REQ-019 SHALL, otherwise, enter BOUNCE and toggle pb on the edge after acceptance (toggle 1).
REQ-020 SHALL make 2*BOUNCES+1 toggles in total, so that the final pb level equals the target.
REQ-021 SHALL space toggle k+1 exactly 1+lfsr[GAP_W-1:0] cycles after toggle k, with the LFSR value sampled at toggle k.
REQ-022 SHALL advance the LFSR exactly once per toggle.
REQ-023 SHALL use a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting left with the feedback bit entering bit 0.
REQ-024 SHALL enter SETTLE after the final toggle and hold pb constant for SETTLE cycles, then enter FIN.
REQ-025 SHALL, in FIN, assert done for exactly one cycle and return to IDLE on the next edge; req_ready SHALL rise together with the return to IDLE.
REQ-026 SHALL drive busy high in BOUNCE, SETTLE and FIN, and low in IDLE.
REQ-027 SHALL honour seed_load only in IDLE and ignore it in all other states.
REQ-028 SHALL, when seed_load and request acceptance occur on the same edge, load the seed first, so the new seed sets the first gap.
REQ-029 SHALL replace a loaded seed of 16'h0000 with 16'hACE1.
REQ-030 SHALL never change pb in IDLE, SETTLE or FIN.

Reset
REQ-031 SHALL, while rst is high at an edge, force state IDLE, pb = ACTIVE_LOW (released), logical state released, busy 0, done 0, req_ready 0 and LFSR 16'hACE1, and clear all counters.
REQ-032 SHALL, when rst asserts mid-BOUNCE or mid-SETTLE, abort the transition with no done pulse.
REQ-033 SHALL drive req_ready high on the first edge after rst deasserts.

Structure
REQ-034 SHALL place the state enum, LFSR_DEFAULT_SEED (16'hACE1) and the tap mask in the shared package bounce_gen_pkg.
REQ-035 SHALL implement the LFSR as sub-module lfsr16, with ports clk, rst, load, seed, step and q.

Verification
REQ-036 SHALL cover a press with BOUNCES=2, SETTLE=16, GAP_W=3, ACTIVE_LOW=1 -> exactly 5 pb edges (1 to 0 to 1 to 0 to 1 to 0), final pb=0, each gap 1..8 cycles and matching a model LFSR, done one cycle after 16 stable cycles.
REQ-037 SHALL cover a release request while already released -> no pb edge, done high in the cycle after acceptance, busy high for 1 cycle.
REQ-038 SHALL cover rst asserted at the 3rd toggle -> pb=1 and busy=0 on the next edge, no done pulse, req_ready=1 after rst deasserts.
REQ-039 SHALL cover seed_load with seed=16'h0000 followed by a press -> gap sequence identical to seed 16'hACE1.
REQ-040 SHALL cover req_valid held high throughout a transition -> only one acceptance until done; the next request is accepted on the edge where req_ready first returns high.
REQ-041 SHALL cover seed_load with seed=16'h0001 together with acceptance -> first gap = 1+(16'h0001 & 3'h7) = 2 cycles.

Source files
------------

// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the bouncing pushbutton emulator.
// Holds the FSM state enum, the LFSR default seed, tap mask and step function.
package bounce_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BOUNCE,
    ST_SETTLE,
    ST_FIN
  } state_t;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // x^16+x^14+x^13+x^11+1 as left-shift taps: bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Longest settle count minus one fits in this many bits
  localparam int SET_W = 20;

  localparam int TOG_W = 5;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reset, seed load and step enable.
// Ports: clk, rst, load, seed[15:0], step, q[15:0]; a zero seed maps to the default.
module lfsr16
  import bounce_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] seed_fix;

  // All-zero is the lock-up state of an XOR LFSR
  assign seed_fix = (seed == 16'h0000)
                  ? LFSR_DEFAULT_SEED
                  : seed;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      q <= seed_fix;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/bounce_gen.sv
// Emulated bouncing pushbutton: on request, glitches pb with random gaps then settles.
// Ports: clk, rst, req_valid/req_press/req_ready, seed_load/seed, pb, busy, done.
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter int BOUNCES    = 3,
  parameter int GAP_W      = 10,
  parameter int SETTLE     = 4096,
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_press,
  output logic        req_ready,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic        pb,
  output logic        busy,
  output logic        done
);

  localparam logic [TOG_W-1:0] N_TOG =
    TOG_W'(2 * BOUNCES + 1);
  localparam logic [SET_W-1:0] SET_M1 =
    SET_W'(SETTLE - 1);
  localparam logic PB_REL = (ACTIVE_LOW != 0);

  state_t state;
  state_t state_n;

  logic pb_n;
  logic busy_n;
  logic done_n;
  logic ready_n;
  logic pressed;
  logic pressed_n;

  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_cnt_n;
  logic [SET_W-1:0] set_cnt;
  logic [SET_W-1:0] set_cnt_n;
  logic [TOG_W-1:0] tog_cnt;
  logic [TOG_W-1:0] tog_cnt_n;

  logic        accept;
  logic        tog;
  logic        ld;
  logic [15:0] q;
  logic        unused_q;

  assign accept = (state == ST_IDLE)
                & req_valid
                & req_ready;

  // Seed is honoured only while idle; it lands
  // on the acceptance edge so it sets gap 1
  assign ld = seed_load & (state == ST_IDLE);

  assign tog = (state == ST_BOUNCE)
             & (gap_cnt == '0);

  // Only the low GAP_W bits feed the gap
  assign unused_q = ^q;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (ld),
    .seed (seed),
    .step (tog),
    .q    (q)
  );

  always_comb begin
    state_n   = state;
    pb_n      = pb;
    pressed_n = pressed;
    gap_cnt_n = gap_cnt;
    set_cnt_n = set_cnt;
    tog_cnt_n = tog_cnt;
    done_n    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          pressed_n = req_press;
          tog_cnt_n = '0;
          // Zero gap makes toggle 1 land on
          // the edge right after acceptance
          gap_cnt_n = '0;
          if (req_press == pressed) begin
            state_n = ST_FIN;
            done_n  = 1'b1;
          end else begin
            state_n = ST_BOUNCE;
          end
        end
      end

      ST_BOUNCE: begin
        if (tog) begin
          pb_n      = ~pb;
          tog_cnt_n = tog_cnt + 1'b1;
          // Counts down to zero, so the next
          // toggle is 1+q[GAP_W-1:0] away
          gap_cnt_n = q[GAP_W-1:0];
          if (tog_cnt_n == N_TOG) begin
            state_n   = ST_SETTLE;
            set_cnt_n = SET_M1;
          end
        end else begin
          gap_cnt_n = gap_cnt - 1'b1;
        end
      end

      ST_SETTLE: begin
        if (set_cnt == '0) begin
          state_n = ST_FIN;
          done_n  = 1'b1;
        end else begin
          set_cnt_n = set_cnt - 1'b1;
        end
      end

      ST_FIN: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n  = (state_n != ST_IDLE);
    ready_n = (state_n == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pb        <= PB_REL;
      pressed   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b0;
      gap_cnt   <= '0;
      set_cnt   <= '0;
      tog_cnt   <= '0;
    end else begin
      state     <= state_n;
      pb        <= pb_n;
      pressed   <= pressed_n;
      busy      <= busy_n;
      done      <= done_n;
      req_ready <= ready_n;
      gap_cnt   <= gap_cnt_n;
      set_cnt   <= set_cnt_n;
      tog_cnt   <= tog_cnt_n;
    end
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Self-checking bench for bounce_gen with a timeline-level reference model.
// Randomized transitions and seeds; directed reset, no-op, abort and seed cases.
module tb_bounce_gen;

  localparam int B  = 2;
  localparam int GW = 3;
  localparam int ST = 16;
  localparam int AL = 1;
  localparam int NT = 2 * B + 1;
  localparam logic [15:0] GMASK = 16'((1 << GW) - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_press = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0;
  logic        req_ready;
  logic        pb;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_lfsr;
  bit          m_pressed;
  int          exp_tog[$];
  int          exp_done;

  int obs_tog[$];
  int obs_done_n;
  int obs_done_at;
  int obs_idle_at;
  bit obs_ready;
  bit obs_pb;
  bit pb_pre;
  bit hold_valid = 1'b0;

  always #5 clk = ~clk;

  bounce_gen #(
    .BOUNCES    (B),
    .GAP_W      (GW),
    .SETTLE     (ST),
    .ACTIVE_LOW (AL)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_press (req_press),
    .req_ready (req_ready),
    .seed_load (seed_load),
    .seed      (seed),
    .pb        (pb),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [15:0] ref_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  // Offsets count negedges after the acceptance edge (0 = right after it)
  function automatic void build_exp();
    int t;
    t = 1;
    exp_tog.delete();
    for (int k = 0; k < NT; k++) begin
      exp_tog.push_back(t);
      t += 1 + int'(m_lfsr & GMASK);
      m_lfsr = ref_next(m_lfsr);
    end
    exp_done = exp_tog[NT-1] + ST;
  endfunction

  task automatic launch(input bit tgt, input bit ld, input logic [15:0] sd);
    int w;
    w = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (w >= 200) begin
      n_err++;
      $display("FAIL launch_ready: req_ready=%b, required 1", req_ready);
    end
    pb_pre    = pb;
    req_valid = 1'b1;
    req_press = tgt;
    seed_load = ld;
    seed      = sd;
    @(posedge clk);
  endtask

  task automatic capture(input int limit);
    bit prev;
    prev = pb_pre;
    obs_tog.delete();
    obs_done_n  = 0;
    obs_done_at = -1;
    obs_idle_at = -1;
    obs_ready   = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (!hold_valid) req_valid = 1'b0;
      seed_load = 1'b0;
      if (pb !== prev) obs_tog.push_back(k);
      prev = pb;
      if (done === 1'b1) begin
        obs_done_n++;
        obs_done_at = k;
      end
      if (busy === 1'b0) begin
        obs_idle_at = k;
        obs_ready   = req_ready;
        break;
      end
    end
    obs_pb = pb;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pb !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pb: got %b, required 1", pb);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_busy: got %b, required 0", busy);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_done: got %b, required 0", done);
    end
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_ready: got %b, required 0", req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_ready_rise: got %b, required 1", req_ready);
    end
    m_lfsr    = 16'hACE1;
    m_pressed = 1'b0;
  endtask

  task automatic test_press();
    bit ok;
    build_exp();
    m_pressed = 1'b1;
    launch(1'b1, 1'b0, 16'h0);
    capture(400);
    n_cmp++;
    if (obs_tog.size() != NT) begin
      n_err++;
      $display("FAIL press_edges: got %0d, required %0d", obs_tog.size(), NT);
    end
    ok = (obs_tog.size() == exp_tog.size());
    if (ok) foreach (exp_tog[i]) if (obs_tog[i] != exp_tog[i]) ok = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL press_times: got %p, required %p", obs_tog, exp_tog);
    end
    ok = 1'b1;
    for (int i = 1; i < obs_tog.size(); i++) begin
      if (obs_tog[i] - obs_tog[i-1] < 1 || obs_tog[i] - obs_tog[i-1] > 8) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL press_gap_range: got %p, required gaps 1..8", obs_tog);
    end
    n_cmp++;
    if (obs_pb !== 1'b0) begin
      n_err++;
      $display("FAIL press_final_pb: got %b, required 0", obs_pb);
    end
    n_cmp++;
    if (obs_done_at != exp_done || obs_done_n != 1) begin
      n_err++;
      $display("FAIL press_done: at %0d x%0d, required at %0d x1",
               obs_done_at, obs_done_n, exp_done);
    end
    n_cmp++;
    if (obs_idle_at != exp_done + 1 || obs_ready !== 1'b1) begin
      n_err++;
      $display("FAIL press_idle: at %0d ready=%b, required at %0d ready=1",
               obs_idle_at, obs_ready, exp_done + 1);
    end
  endtask

  task automatic test_noop();
    build_exp();
    m_pressed = 1'b0;
    launch(1'b0, 1'b0, 16'h0);
    capture(400);
    n_cmp++;
    if (obs_tog.size() != NT || obs_pb !== 1'b1) begin
      n_err++;
      $display("FAIL release_real: edges %0d pb=%b, required %0d pb=1",
               obs_tog.size(), obs_pb, NT);
    end
    launch(1'b0, 1'b0, 16'h0);
    capture(50);
    n_cmp++;
    if (obs_tog.size() != 0) begin
      n_err++;
      $display("FAIL noop_edges: got %0d, required 0", obs_tog.size());
    end
    n_cmp++;
    if (obs_done_at != 0 || obs_done_n != 1) begin
      n_err++;
      $display("FAIL noop_done: at %0d x%0d, required at 0 x1",
               obs_done_at, obs_done_n);
    end
    n_cmp++;
    if (obs_idle_at != 1 || obs_ready !== 1'b1) begin
      n_err++;
      $display("FAIL noop_busy: idle at %0d ready=%b, required at 1 ready=1",
               obs_idle_at, obs_ready);
    end
  endtask

  task automatic test_seed_zero();
    int ref_t[$];
    bit ok;
    @(negedge clk);
    seed_load = 1'b1;
    seed      = 16'h0000;
    @(negedge clk);
    seed_load = 1'b0;
    m_lfsr = 16'hACE1;
    build_exp();
    ref_t = exp_tog;
    m_pressed = 1'b1;
    launch(1'b1, 1'b0, 16'h0);
    capture(400);
    ok = (obs_tog.size() == ref_t.size());
    if (ok) foreach (ref_t[i]) if (obs_tog[i] != ref_t[i]) ok = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL seed_zero: got %p, required %p", obs_tog, ref_t);
    end
  endtask

  task automatic test_seed_accept();
    bit ok;
    m_lfsr = 16'h0001;
    build_exp();
    m_pressed = 1'b0;
    launch(1'b0, 1'b1, 16'h0001);
    capture(400);
    n_cmp++;
    if (obs_tog.size() < 2 || obs_tog[1] - obs_tog[0] != 2) begin
      n_err++;
      $display("FAIL seed_accept_gap1: got %p, required first gap 2", obs_tog);
    end
    ok = (obs_tog.size() == exp_tog.size());
    if (ok) foreach (exp_tog[i]) if (obs_tog[i] != exp_tog[i]) ok = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL seed_accept_seq: got %p, required %p", obs_tog, exp_tog);
    end
  endtask

  task automatic test_abort();
    bit prev;
    int cnt;
    int dn;
    launch(1'b1, 1'b0, 16'h0);
    prev = pb_pre;
    cnt  = 0;
    dn   = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (pb !== prev) cnt++;
      prev = pb;
      if (done === 1'b1) dn++;
      if (cnt == 3) break;
    end
    n_cmp++;
    if (cnt != 3) begin
      n_err++;
      $display("FAIL abort_reach3: got %0d toggles, required 3", cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (pb !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state: pb=%b busy=%b, required pb=1 busy=0", pb, busy);
    end
    if (done === 1'b1) dn++;
    @(negedge clk);
    if (done === 1'b1) dn++;
    rst = 1'b0;
    @(negedge clk);
    if (done === 1'b1) dn++;
    n_cmp++;
    if (dn != 0) begin
      n_err++;
      $display("FAIL abort_done: got %0d pulses, required 0", dn);
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_ready: got %b, required 1", req_ready);
    end
    m_lfsr    = 16'hACE1;
    m_pressed = 1'b0;
  endtask

  task automatic test_back_to_back();
    build_exp();
    m_pressed  = 1'b1;
    hold_valid = 1'b1;
    launch(1'b1, 1'b0, 16'h0);
    capture(400);
    n_cmp++;
    if (obs_tog.size() != NT || obs_done_n != 1 || obs_done_at != exp_done) begin
      n_err++;
      $display("FAIL b2b_single: edges %0d done x%0d at %0d, required %0d x1 at %0d",
               obs_tog.size(), obs_done_n, obs_done_at, NT, exp_done);
    end
    n_cmp++;
    if (obs_idle_at != exp_done + 1 || obs_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ready: idle at %0d ready=%b, required at %0d ready=1",
               obs_idle_at, obs_ready, exp_done + 1);
    end
    @(negedge clk);
    hold_valid = 1'b0;
    req_valid  = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_next_accept: busy=%b done=%b, required 1 1", busy, done);
    end
  endtask

  task automatic test_random();
    bit tgt;
    bit ld;
    bit ok;
    logic [15:0] sd;
    for (int i = 0; i < 24; i++) begin
      tgt = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 2) == 0);
      sd  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      if (ld) m_lfsr = (sd == 16'h0000) ? 16'hACE1 : sd;
      if (tgt == m_pressed) begin
        exp_tog.delete();
        exp_done = 0;
      end else begin
        build_exp();
      end
      m_pressed = tgt;
      launch(tgt, ld, sd);
      capture(400);
      ok = (obs_tog.size() == exp_tog.size());
      if (ok) foreach (exp_tog[j]) if (obs_tog[j] != exp_tog[j]) ok = 1'b0;
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL rnd%0d_times: got %p, required %p", i, obs_tog, exp_tog);
      end
      n_cmp++;
      if (obs_done_at != exp_done || obs_done_n != 1) begin
        n_err++;
        $display("FAIL rnd%0d_done: at %0d x%0d, required at %0d x1",
                 i, obs_done_at, obs_done_n, exp_done);
      end
      n_cmp++;
      if (obs_idle_at != exp_done + 1 || obs_ready !== 1'b1) begin
        n_err++;
        $display("FAIL rnd%0d_idle: at %0d ready=%b, required at %0d ready=1",
                 i, obs_idle_at, obs_ready, exp_done + 1);
      end
      n_cmp++;
      if (obs_pb !== (m_pressed ^ 1'(AL))) begin
        n_err++;
        $display("FAIL rnd%0d_pb: got %b, required %b",
                 i, obs_pb, m_pressed ^ 1'(AL));
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_noop();
    test_seed_zero();
    test_seed_accept();
    test_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
